ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
//  EX->MEM pipeline register of the 5-stage core, directly downstream of the ALU/PADDSB execute logic.
//  Latches the execute result, per-nibble saturation vector, destination and memory controls.
//  Owns the architectural N/Z/V flag register and a sticky halt latch.
//  Counts saturating PADDSB lanes for debug.
// PARAMETERS
//  DATA_W   16  datapath width
//  RADDR_W  4   register-file index width
//  LANES    4   PADDSB nibble lanes (DATA_W/4)
//  CNT_W    16  saturation event counter width
// PORTS
//  clk           in   1        core clock; all state updates on rising edge
//  rst           in   1        synchronous, active-high reset
//  stall         in   1        MEM stage busy: hold every register
//  flush         in   1        replace the captured entry with a bubble
//  in_valid      in   1        EX holds a real instruction
//  in_op         in   4        opcode (ADD=0,SUB=1,XOR=2,RED=3,SLL=4,SRA=5,ROR=6,PADDSB=7, others non-ALU)
//  in_result     in   DATA_W   ALU/PADDSB result
//  in_sat_v      in   LANES    per-lane PADDSB overflow (saturated) bits
//  in_n,in_z,in_v in  1 each   flag candidates computed by EX
//  in_rd         in   RADDR_W  destination register
//  in_reg_we     in   1        register write enable
//  in_mem_re     in   1        load
//  in_mem_we     in   1        store
//  in_mem_wdata  in   DATA_W   store data (post-forwarding)
//  in_halt       in   1        HLT instruction
//  out_valid, out_op, out_result, out_sat_v, out_rd, out_reg_we, out_mem_re, out_mem_we,
//  out_mem_wdata, out_halt  out  (widths as inputs)  registered copies to MEM
//  flag_n,flag_z,flag_v  out 1 each   architectural flags, consumed by branch logic
//  halted        out  1        sticky: a HLT has passed EX
//  sat_cnt       out  CNT_W    saturating count of saturated PADDSB lanes
// BEHAVIOUR
//  - Reset: all outputs 0 (out_valid=0, flags=0, halted=0, sat_cnt=0); rst beats every other input.
//  - Priority per edge: rst > stall > flush > capture.
//  - stall=1: all registers, flags, halted, sat_cnt hold; flush in the same cycle is ignored (upstream re-asserts).
//  - flush=1 (no stall): out_valid, out_reg_we, out_mem_re, out_mem_we, out_halt <= 0; data fields don't-care
//    (implemented as hold); flags/sat_cnt unchanged.
//  - Capture (no stall/flush): all out_* <= in_* in one cycle (latency 1); controls gated by in_valid,
//    i.e. in_valid=0 captures a bubble.
//  - halted=1: captures are forced to bubbles, flags/sat_cnt freeze; only rst clears halted.
//  - Entry "commits" = captured with in_valid=1 and halted=0.
//  - Flag update on commit only: ADD/SUB -> N,Z,V <= in_n,in_z,in_v; XOR/SLL/SRA/ROR -> Z only;
//    RED, PADDSB, non-ALU -> no change. Visible the cycle after capture.
//  - in_halt on commit: out_halt=1 and halted<=1 on that same edge.
//  - sat_cnt: on commit of PADDSB, sat_cnt += popcount(in_sat_v) (0..LANES); clamps at 2^CNT_W-1, never wraps.
//  - out_sat_v captured for every commit, forced 0 for non-PADDSB ops.
//  - No combinational path input->output.
// TESTING
//  1. rst=1 with all inputs 1 -> next edge all outputs 0; release, ADD result 0x1234 rd=3 -> next cycle
//     out_valid=1, out_result=0x1234, out_rd=3.
//  2. SUB with in_n=1,in_z=0,in_v=1, then XOR with in_z=1,in_n=0 -> flags N=1,Z=0,V=1 then N=1,Z=1,V=1;
//     PADDSB/RED leave flags unchanged.
//  3. PADDSB in_sat_v=4'b1011 twice -> sat_cnt 3 then 6; preload near max 0xFFFE + 3 lanes -> 0xFFFF held.
//  4. Valid LD captured, stall=1 3 cycles with new EX inputs and flush=1 -> outputs unchanged;
//     stall=0, flush=1 -> out_valid=0, out_mem_re=0.
//  5. HLT committed -> out_halt=1, halted=1; following ADD with in_valid=1 -> out_valid=0, flags frozen;
//     rst -> halted=0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM pipeline register with flag register, halt latch and PADDSB saturation counter
module ex_mem_pipe #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [3:0]         in_op,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [LANES-1:0]   in_sat_v,
  input  logic               in_n,
  input  logic               in_z,
  input  logic               in_v,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_we,
  input  logic               in_mem_re,
  input  logic               in_mem_we,
  input  logic [DATA_W-1:0]  in_mem_wdata,
  input  logic               in_halt,
  output logic               out_valid,
  output logic [3:0]         out_op,
  output logic [DATA_W-1:0]  out_result,
  output logic [LANES-1:0]   out_sat_v,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_we,
  output logic               out_mem_re,
  output logic               out_mem_we,
  output logic [DATA_W-1:0]  out_mem_wdata,
  output logic               out_halt,
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_v,
  output logic               halted,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam int LCW = $clog2(LANES + 1);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;

  logic             commit;
  logic             is_paddsb;
  logic [LCW-1:0]   lane_cnt;
  logic [CNT_W:0]   sat_sum;

  assign commit    = in_valid & ~halted;
  assign is_paddsb = (in_op == OP_PADDSB);

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_cnt = lane_cnt + LCW'(in_sat_v[i]);
    end
  end

  // One extra bit catches the carry so the counter clamps instead of wrapping.
  assign sat_sum = {1'b0, sat_cnt} + (CNT_W + 1)'(lane_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_op        <= '0;
      out_result    <= '0;
      out_sat_v     <= '0;
      out_rd        <= '0;
      out_reg_we    <= 1'b0;
      out_mem_re    <= 1'b0;
      out_mem_we    <= 1'b0;
      out_mem_wdata <= '0;
      out_halt      <= 1'b0;
      flag_n        <= 1'b0;
      flag_z        <= 1'b0;
      flag_v        <= 1'b0;
      halted        <= 1'b0;
      sat_cnt       <= '0;
    end else if (!stall) begin
      if (flush) begin
        out_valid  <= 1'b0;
        out_reg_we <= 1'b0;
        out_mem_re <= 1'b0;
        out_mem_we <= 1'b0;
        out_halt   <= 1'b0;
      end else begin
        out_valid     <= commit;
        out_reg_we    <= commit & in_reg_we;
        out_mem_re    <= commit & in_mem_re;
        out_mem_we    <= commit & in_mem_we;
        out_halt      <= commit & in_halt;
        out_op        <= in_op;
        out_result    <= in_result;
        out_sat_v     <= is_paddsb ? in_sat_v : '0;
        out_rd        <= in_rd;
        out_mem_wdata <= in_mem_wdata;

        if (commit) begin
          unique case (in_op)
            OP_ADD, OP_SUB: begin
              flag_n <= in_n;
              flag_z <= in_z;
              flag_v <= in_v;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z <= in_z;
            default: ;
          endcase
          if (is_paddsb) begin
            sat_cnt <= sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
          end
          if (in_halt) begin
            halted <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - randomized and directed self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [15:0] in_result;
  logic [3:0]  in_sat_v;
  logic        in_n, in_z, in_v;
  logic [3:0]  in_rd;
  logic        in_reg_we, in_mem_re, in_mem_we;
  logic [15:0] in_mem_wdata;
  logic        in_halt;
  logic        out_valid;
  logic [3:0]  out_op;
  logic [15:0] out_result;
  logic [3:0]  out_sat_v;
  logic [3:0]  out_rd;
  logic        out_reg_we, out_mem_re, out_mem_we;
  logic [15:0] out_mem_wdata;
  logic        out_halt;
  logic        flag_n, flag_z, flag_v;
  logic        halted;
  logic [15:0] sat_cnt;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_result(in_result), .in_sat_v(in_sat_v),
    .in_n(in_n), .in_z(in_z), .in_v(in_v), .in_rd(in_rd),
    .in_reg_we(in_reg_we), .in_mem_re(in_mem_re), .in_mem_we(in_mem_we),
    .in_mem_wdata(in_mem_wdata), .in_halt(in_halt),
    .out_valid(out_valid), .out_op(out_op), .out_result(out_result), .out_sat_v(out_sat_v),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_mem_wdata(out_mem_wdata), .out_halt(out_halt),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .halted(halted), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural expectation of the visible state.
  bit       m_valid, m_reg_we, m_mem_re, m_mem_we, m_halt;
  bit [3:0] m_op, m_sat_v, m_rd;
  bit [15:0] m_result, m_wdata;
  bit       m_n, m_z, m_v, m_halted;
  int       m_sat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    bit c;
    if (rst) begin
      {m_valid, m_reg_we, m_mem_re, m_mem_we, m_halt} = '0;
      m_op = 0; m_sat_v = 0; m_rd = 0; m_result = 0; m_wdata = 0;
      {m_n, m_z, m_v, m_halted} = '0;
      m_sat = 0;
    end else if (!stall) begin
      if (flush) begin
        {m_valid, m_reg_we, m_mem_re, m_mem_we, m_halt} = '0;
      end else begin
        c = in_valid && !m_halted;
        m_valid  = c;
        m_reg_we = c && in_reg_we;
        m_mem_re = c && in_mem_re;
        m_mem_we = c && in_mem_we;
        m_halt   = c && in_halt;
        if (c) begin
          m_op = in_op; m_result = in_result; m_rd = in_rd; m_wdata = in_mem_wdata;
          m_sat_v = (in_op == 4'd7) ? in_sat_v : 4'd0;
          if (in_op <= 4'd1) begin
            m_n = in_n; m_z = in_z; m_v = in_v;
          end else if (in_op == 4'd2 || (in_op >= 4'd4 && in_op <= 4'd6)) begin
            m_z = in_z;
          end else if (in_op == 4'd7) begin
            m_sat = m_sat + $countones(in_sat_v);
            if (m_sat > 65535) m_sat = 65535;
          end
          if (in_halt) m_halted = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid",  out_valid,  m_valid);
    chk("out_reg_we", out_reg_we, m_reg_we);
    chk("out_mem_re", out_mem_re, m_mem_re);
    chk("out_mem_we", out_mem_we, m_mem_we);
    chk("out_halt",   out_halt,   m_halt);
    chk("flags",      {flag_n, flag_z, flag_v}, {m_n, m_z, m_v});
    chk("halted",     halted,     m_halted);
    chk("sat_cnt",    sat_cnt,    m_sat[15:0]);
    if (m_valid) begin
      chk("out_op",        out_op,        m_op);
      chk("out_result",    out_result,    m_result);
      chk("out_sat_v",     out_sat_v,     m_sat_v);
      chk("out_rd",        out_rd,        m_rd);
      chk("out_mem_wdata", out_mem_wdata, m_wdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_in();
    in_valid = 1'($urandom); in_op = 4'($urandom); in_result = 16'($urandom);
    in_sat_v = 4'($urandom); in_n = 1'($urandom); in_z = 1'($urandom); in_v = 1'($urandom);
    in_rd = 4'($urandom); in_reg_we = 1'($urandom); in_mem_re = 1'($urandom);
    in_mem_we = 1'($urandom); in_mem_wdata = 16'($urandom); in_halt = 1'b0;
  endtask

  task automatic op(input logic [3:0] o, input logic [3:0] sv, input logic n, input logic z, input logic v);
    rand_in();
    rst = 0; stall = 0; flush = 0; in_valid = 1; in_halt = 0;
    in_op = o; in_sat_v = sv; in_n = n; in_z = z; in_v = v;
  endtask

  initial begin
    rst = 1; stall = 1; flush = 1;
    {in_valid, in_n, in_z, in_v, in_reg_we, in_mem_re, in_mem_we, in_halt} = '1;
    in_op = '1; in_result = '1; in_sat_v = '1; in_rd = '1; in_mem_wdata = '1;
    @(negedge clk);
    step();
    chk("rst_valid",  out_valid, 1'b0);
    chk("rst_result", out_result, 16'h0);
    chk("rst_all",    {out_reg_we, out_mem_re, out_mem_we, out_halt, flag_n, flag_z, flag_v, halted}, 8'h00);
    chk("rst_satcnt", sat_cnt, 16'h0);

    op(4'd0, 4'h0, 0, 0, 0); in_result = 16'h1234; in_rd = 4'd3;
    step();
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", out_result, 16'h1234);
    chk("add_rd", out_rd, 4'd3);

    op(4'd1, 4'h0, 1, 0, 1); step();
    chk("sub_flags", {flag_n, flag_z, flag_v}, 3'b101);
    op(4'd2, 4'h0, 0, 1, 0); step();
    chk("xor_flags", {flag_n, flag_z, flag_v}, 3'b111);
    op(4'd7, 4'h0, 0, 0, 0); step();
    op(4'd3, 4'h0, 0, 0, 0); step();
    chk("paddsb_red_flags", {flag_n, flag_z, flag_v}, 3'b111);

    rst = 1; step();
    op(4'd7, 4'b1011, 0, 0, 0); step();
    chk("sat_3", sat_cnt, 16'd3);
    chk("sat_v", out_sat_v, 4'b1011);
    step();
    chk("sat_6", sat_cnt, 16'd6);

    rst = 1; step();
    for (int i = 0; i < 16383; i++) begin
      op(4'd7, 4'b1111, 0, 0, 0); step();
    end
    op(4'd7, 4'b0011, 0, 0, 0); step();
    chk("sat_fffe", sat_cnt, 16'hFFFE);
    op(4'd7, 4'b1011, 0, 0, 0); step();
    chk("sat_clamp", sat_cnt, 16'hFFFF);
    op(4'd7, 4'b1111, 0, 0, 0); step();
    chk("sat_hold", sat_cnt, 16'hFFFF);

    op(4'd8, 4'h0, 0, 0, 0); in_mem_re = 1; in_reg_we = 1; in_mem_we = 0; step();
    for (int i = 0; i < 3; i++) begin
      rand_in(); stall = 1; flush = 1; in_valid = 1; step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_mem_re", out_mem_re, 1'b1);
    end
    rand_in(); stall = 0; flush = 1; step();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_mem_re", out_mem_re, 1'b0);

    op(4'd1, 4'h0, 0, 1, 0); step();
    op(4'd9, 4'h0, 0, 0, 0); in_halt = 1; step();
    chk("hlt_out_halt", out_halt, 1'b1);
    chk("hlt_halted", halted, 1'b1);
    op(4'd0, 4'h0, 1, 0, 1); step();
    chk("halted_bubble", out_valid, 1'b0);
    chk("halted_flags", {flag_n, flag_z, flag_v}, 3'b010);
    rst = 1; step();
    chk("rst_unhalt", halted, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      in_halt = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) == 0) in_op = 4'd7;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
